tdm_demux: RTL and testbench

Time-division demultiplexer: the receive end of the TDM mux path. A serial word stream arrives on one input, with a start-of-frame marker on channel 0. The block steers each word to its channel slot and presents a complete frame of N words in parallel. It sits after the TDM mux/link stage and feeds per-channel consumers, which sample `dout` on the `frame_valid` pulse.

---
 rtl/tdm_demux.sv | 91 +++++++++
 tb/tb_tdm_demux.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Receive side of the TDM link: steers a serial word stream into per-channel
// slots and presents each complete frame in parallel on dout.
//
// state | meaning
// HUNT  | unsynchronised, waiting for a word marked sof
// RECV  | synchronised, cnt is the channel of the next accepted word
module tdm_demux #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vin,
    input  logic                 sof,
    input  logic [W-1:0]         din,
    output logic [N*W-1:0]       dout,
    output logic                 frame_valid,
    output logic [((N > 2) ? $clog2(N) : 1)-1:0] ch,
    output logic                 serr
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ZERO = '0;
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  stage [0:N-2];
    logic [N*W-1:0] frame_next;

    // The last word bypasses the staging buffer and lands directly in dout.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < N - 1; k++) begin
            frame_next[k*W +: W] = stage[k];
        end
        frame_next[(N-1)*W +: W] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            cnt         <= ZERO;
            dout        <= '0;
            frame_valid <= 1'b0;
            serr        <= 1'b0;
            for (int k = 0; k < N - 1; k++) begin
                stage[k] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            serr        <= 1'b0;
            if (vin) begin
                case (state)
                    HUNT: begin
                        if (sof) begin
                            stage[0] <= din;
                            cnt      <= ONE;
                            state    <= RECV;
                        end
                    end
                    default: begin
                        if (sof && (cnt != ZERO)) begin
                            // Short frame: restart on the new sof word.
                            stage[0] <= din;
                            cnt      <= ONE;
                            serr     <= 1'b1;
                        end else if (!sof && (cnt == ZERO)) begin
                            state <= HUNT;
                            serr  <= 1'b1;
                        end else if (cnt == LAST) begin
                            dout        <= frame_next;
                            frame_valid <= 1'b1;
                            cnt         <= ZERO;
                        end else begin
                            stage[cnt] <= din;
                            cnt        <= cnt + ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign ch = (state == RECV) ? cnt : ZERO;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed vector table, a gapped-input sequence and a
// randomized run checked against a queue-based frame model.
module tb_tdm_demux;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst, vin, sof;
    logic [W-1:0]   din;
    logic [N*W-1:0] dout;
    logic           frame_valid, serr;
    logic [CW-1:0]  ch;

    int tests = 0;
    int fails = 0;

    tdm_demux #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst), .vin(vin), .sof(sof), .din(din),
        .dout(dout), .frame_valid(frame_valid), .ch(ch), .serr(serr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           r, v, s;
        logic [W-1:0]   d;
        logic           fv, se;
        logic [CW-1:0]  c;
        logic [N*W-1:0] q;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the current frame is just the list of words collected so far.
    bit             m_sync;
    logic [W-1:0]   m_words[$];
    logic [N*W-1:0] m_dout;
    logic           m_fv, m_serr;
    logic [CW-1:0]  m_ch;

    task automatic model_step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        m_fv = 1'b0;
        m_serr = 1'b0;
        if (r) begin
            m_sync = 0;
            m_words.delete();
            m_dout = '0;
        end else if (v) begin
            if (!m_sync) begin
                if (s) begin
                    m_sync = 1;
                    m_words.delete();
                    m_words.push_back(d);
                end
            end else if (s && m_words.size() != 0) begin
                m_serr = 1'b1;
                m_words.delete();
                m_words.push_back(d);
            end else if (!s && m_words.size() == 0) begin
                m_serr = 1'b1;
                m_sync = 0;
            end else begin
                m_words.push_back(d);
                if (m_words.size() == N) begin
                    for (int k = 0; k < N; k++) m_dout[k*W +: W] = m_words[k];
                    m_fv = 1'b1;
                    m_words.delete();
                end
            end
        end
        m_ch = m_sync ? CW'(m_words.size()) : '0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        @(negedge clk);
        rst = r; vin = v; sof = s; din = d;
        @(posedge clk);
        #1;
        model_step(r, v, s, d);
    endtask

    task automatic add(input logic r, input logic v, input logic s, input logic [W-1:0] d,
                       input logic fv, input logic se, input logic [CW-1:0] c, input logic [N*W-1:0] q);
        vec_t x;
        x.r = r; x.v = v; x.s = s; x.d = d; x.fv = fv; x.se = se; x.c = c; x.q = q;
        vecs.push_back(x);
    endtask

    initial begin
        int fv_cnt;
        logic [N*W-1:0] held;
        logic [W-1:0] gw[4];

        rst = 1'b1; vin = 1'b0; sof = 1'b0; din = '0;
        m_sync = 0; m_dout = '0; m_fv = 0; m_serr = 0; m_ch = '0;

        //  r  v  s  din    fv se ch dout
        // reset then frame
        add(1, 0, 0, 8'h00, 0, 0, 0, 32'h0);
        add(1, 1, 1, 8'h5A, 0, 0, 0, 32'h0);
        add(0, 1, 1, 8'h11, 0, 0, 1, 32'h0);
        add(0, 1, 0, 8'h22, 0, 0, 2, 32'h0);
        add(0, 1, 0, 8'h33, 0, 0, 3, 32'h0);
        add(0, 1, 0, 8'h44, 1, 0, 0, 32'h44332211);
        add(0, 0, 0, 8'h00, 0, 0, 0, 32'h44332211);
        // hunt discard
        add(1, 0, 0, 8'h00, 0, 0, 0, 32'h0);
        add(0, 1, 0, 8'hAA, 0, 0, 0, 32'h0);
        add(0, 1, 0, 8'hBB, 0, 0, 0, 32'h0);
        add(0, 1, 1, 8'h01, 0, 0, 1, 32'h0);
        add(0, 1, 0, 8'h02, 0, 0, 2, 32'h0);
        add(0, 1, 0, 8'h03, 0, 0, 3, 32'h0);
        add(0, 1, 0, 8'h04, 1, 0, 0, 32'h04030201);
        // early sof
        add(0, 1, 1, 8'h11, 0, 0, 1, 32'h04030201);
        add(0, 1, 0, 8'h22, 0, 0, 2, 32'h04030201);
        add(0, 1, 1, 8'h55, 0, 1, 1, 32'h04030201);
        add(0, 1, 0, 8'h66, 0, 0, 2, 32'h04030201);
        add(0, 1, 0, 8'h77, 0, 0, 3, 32'h04030201);
        add(0, 1, 0, 8'h88, 1, 0, 0, 32'h88776655);
        // sof on the last slot is also a short frame
        add(0, 1, 1, 8'h10, 0, 0, 1, 32'h88776655);
        add(0, 1, 0, 8'h20, 0, 0, 2, 32'h88776655);
        add(0, 1, 0, 8'h30, 0, 0, 3, 32'h88776655);
        add(0, 1, 1, 8'h55, 0, 1, 1, 32'h88776655);
        add(0, 1, 0, 8'h66, 0, 0, 2, 32'h88776655);
        add(0, 1, 0, 8'h77, 0, 0, 3, 32'h88776655);
        add(0, 1, 0, 8'h88, 1, 0, 0, 32'h88776655);
        // missing sof, then hunting (second stray word gives no serr)
        add(0, 1, 0, 8'h99, 0, 1, 0, 32'h88776655);
        add(0, 1, 0, 8'h99, 0, 0, 0, 32'h88776655);
        add(0, 1, 1, 8'hA1, 0, 0, 1, 32'h88776655);
        add(0, 1, 0, 8'hA2, 0, 0, 2, 32'h88776655);
        add(0, 1, 0, 8'hA3, 0, 0, 3, 32'h88776655);
        add(0, 1, 0, 8'hA4, 1, 0, 0, 32'hA4A3A2A1);
        // reset mid-frame, colliding with the last word
        add(0, 1, 1, 8'h11, 0, 0, 1, 32'hA4A3A2A1);
        add(0, 1, 0, 8'h22, 0, 0, 2, 32'hA4A3A2A1);
        add(0, 1, 0, 8'h33, 0, 0, 3, 32'hA4A3A2A1);
        add(1, 1, 0, 8'h44, 0, 0, 0, 32'h0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 32'h0);
        add(0, 1, 0, 8'h55, 0, 0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].d);
            check($sformatf("vec%0d_fv", i),   64'(frame_valid), 64'(vecs[i].fv));
            check($sformatf("vec%0d_serr", i), 64'(serr),        64'(vecs[i].se));
            check($sformatf("vec%0d_ch", i),   64'(ch),          64'(vecs[i].c));
            check($sformatf("vec%0d_dout", i), 64'(dout),        64'(vecs[i].q));
        end

        // Gapped input: 3 idle cycles between words.
        cyc(1, 0, 0, 8'h00);
        gw[0] = 8'h11; gw[1] = 8'h22; gw[2] = 8'h33; gw[3] = 8'h44;
        fv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, (i == 0), gw[i]);
            if (frame_valid) fv_cnt++;
            check($sformatf("gap_ch%0d", i), 64'(ch), 64'((i + 1) % 4));
            if (i < 3) check($sformatf("gap_dout%0d", i), 64'(dout), 64'h0);
            for (int g = 0; g < 3; g++) begin
                cyc(0, 0, 1, 8'hEE);
                if (frame_valid) fv_cnt++;
                check($sformatf("gap_idle_ch%0d_%0d", i, g), 64'(ch), 64'((i + 1) % 4));
            end
        end
        check("gap_dout_final", 64'(dout), 64'h44332211);
        check("gap_fv_count", 64'(fv_cnt), 64'd1);

        // Back-to-back full-rate frames: frame_valid every N cycles.
        fv_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) begin
                cyc(0, 1, (i == 0), W'(f * 16 + i));
                if (frame_valid) fv_cnt++;
                check($sformatf("b2b_fv%0d_%0d", f, i), 64'(frame_valid), 64'(i == N - 1));
            end
        end
        check("b2b_fv_count", 64'(fv_cnt), 64'd3);
        check("b2b_dout", 64'(dout), 64'h23222120);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r, v, s;
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 75);
            s = ($urandom_range(0, 99) < 25);
            cyc(r, v, s, W'($urandom));
            check("rnd_fv",   64'(frame_valid), 64'(m_fv));
            check("rnd_serr", 64'(serr),        64'(m_serr));
            check("rnd_ch",   64'(ch),          64'(m_ch));
            check("rnd_dout", 64'(dout),        64'(m_dout));
        end
        held = dout;
        cyc(0, 0, 0, 8'h00);
        check("final_hold", 64'(dout), 64'(held));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
